// File: rtl/store_buffer_pkg.sv
// Shared sizing defaults and the port-arbitration encoding for the posted-store buffer.
package store_buffer_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_DATA_W = 16;
  localparam int SB_ADDR_W = 16;
  localparam int SB_MEM_AW = 3;

  typedef enum logic [1:0] {
    PORT_IDLE  = 2'd0,
    PORT_LOAD  = 2'd1,
    PORT_DRAIN = 2'd2
  } port_sel_e;

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding lookup: youngest valid entry whose decoded address matches the load.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int DATA_W = SB_DATA_W,
  parameter int MEM_AW = SB_MEM_AW
) (
  input  logic [DEPTH-1:0][MEM_AW-1:0] entry_addr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] entry_data_i,
  input  logic [DEPTH-1:0]             entry_valid_i,
  input  logic [$clog2(DEPTH)-1:0]     head_i,
  input  logic [MEM_AW-1:0]            ld_addr_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest starting at head, so a later match overrides an earlier one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (entry_valid_i[idx] && (entry_addr_i[idx] == ld_addr_i)) begin
        hit_o  = 1'b1;
        data_o = entry_data_i[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO in front of Data_Memory: loads take the shared port unless the buffer is full,
// stores drain in program order whenever the port is free, and buffered data forwards to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int DATA_W = SB_DATA_W,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int MEM_AW = SB_MEM_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_ready,
  output logic [DATA_W-1:0]        ld_data,
  output logic [ADDR_W-1:0]        mem_access_addr,
  output logic [DATA_W-1:0]        mem_write_data,
  output logic                     mem_write_en,
  output logic                     mem_read,
  input  logic [DATA_W-1:0]        mem_read_data,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0][MEM_AW-1:0] addr_low;
  logic [DEPTH-1:0]             valid_q;
  logic [PW-1:0]                head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                count_q, count_d;

  logic        full, enq, drain;
  logic        fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  port_sel_e   port_sel;

  assign full     = (count_q == CW'(DEPTH));
  assign enq      = st_valid & ~full;
  assign st_ready = ~full;
  assign ld_ready = ~full;
  assign sb_empty = (count_q == '0);
  assign sb_count = count_q;
  assign drain    = (port_sel == PORT_DRAIN);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_low[i] = addr_q[i][MEM_AW-1:0];
    end
  end

  sb_fwd_match #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .MEM_AW (MEM_AW)
  ) u_fwd (
    .entry_addr_i  (addr_low),
    .entry_data_i  (data_q),
    .entry_valid_i (valid_q),
    .head_i        (head_q),
    .ld_addr_i     (ld_addr[MEM_AW-1:0]),
    .hit_o         (fwd_hit),
    .data_o        (fwd_data)
  );

  // A full buffer always drains first so a steady load stream cannot starve the stores.
  always_comb begin
    port_sel = PORT_IDLE;
    if (ld_valid && !full) begin
      port_sel = PORT_LOAD;
    end else if (count_q != '0) begin
      port_sel = PORT_DRAIN;
    end
  end

  always_comb begin
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    ld_data         = '0;
    case (port_sel)
      PORT_LOAD: begin
        mem_access_addr = ld_addr;
        mem_read        = 1'b1;
        ld_data         = fwd_hit ? fwd_data : mem_read_data;
      end
      PORT_DRAIN: begin
        mem_access_addr = addr_q[head_q];
        mem_write_data  = data_q[head_q];
        mem_write_en    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    head_d  = head_q + PW'(drain);
    tail_d  = tail_q + PW'(enq);
    count_d = count_q + CW'(enq) - CW'(drain);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // Head and tail only coincide when empty or full, so the clear and set never collide.
      if (drain) begin
        valid_q[head_q] <= 1'b0;
      end
      if (enq) begin
        addr_q[tail_q]  <= st_addr;
        data_q[tail_q]  <= st_data;
        valid_q[tail_q] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, wrap and reset sequences, then random traffic
// checked against a queue-based model of the buffer and an array model of Data_Memory.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk, rst_n;
  logic        st_valid, ld_valid;
  logic [15:0] st_addr, st_data, ld_addr;
  logic        st_ready, ld_ready;
  logic [15:0] ld_data, mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read, sb_empty;
  logic [2:0]  sb_count;

  logic [15:0] env_mem [8];
  logic        mem_init;

  int vectors = 0;
  int miscompares = 0;

  store_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .st_valid        (st_valid),
    .st_addr         (st_addr),
    .st_data         (st_data),
    .st_ready        (st_ready),
    .ld_valid        (ld_valid),
    .ld_addr         (ld_addr),
    .ld_ready        (ld_ready),
    .ld_data         (ld_data),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data),
    .sb_empty        (sb_empty),
    .sb_count        (sb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data_Memory stand-in: decodes the low 3 address bits, writes at the clock edge.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 8; i++) env_mem[i] <= 16'hA000 + 16'(i);
    end else if (mem_write_en) begin
      env_mem[mem_access_addr[2:0]] <= mem_write_data;
    end
  end
  assign mem_read_data = env_mem[mem_access_addr[2:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                       input logic lv, input logic [15:0] la);
    @(negedge clk);
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    st_valid = 0; st_addr = 0; st_data = 0; ld_valid = 0; ld_addr = 0;
    rst_n = 0; mem_init = 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1; mem_init = 0;
  endtask

  typedef struct {
    logic        sv;
    logic [15:0] sa, sd;
    logic        lv;
    logic [15:0] la;
    logic        e_st_rdy, e_ld_rdy;
    logic [15:0] e_ld_data;
    logic        e_we, e_rd;
    logic [15:0] e_addr, e_wdata;
    int          e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                              input logic lv, input logic [15:0] la,
                              input logic esr, input logic elr, input logic [15:0] eld,
                              input logic ewe, input logic erd, input logic [15:0] ea,
                              input logic [15:0] ewd, input int ec);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la;
    v.e_st_rdy = esr; v.e_ld_rdy = elr; v.e_ld_data = eld;
    v.e_we = ewe; v.e_rd = erd; v.e_addr = ea; v.e_wdata = ewd; v.e_cnt = ec;
    return v;
  endfunction

  // Reference model for random traffic.
  typedef struct { logic [15:0] a; logic [15:0] d; } ent_t;
  ent_t        mq[$];
  logic [15:0] exp_mem [8];

  task automatic step(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                      input logic lv, input logic [15:0] la);
    bit          full, grant, drn;
    logic [15:0] e_ld, e_addr, e_wd;
    drive(sv, sa, sd, lv, la);
    full  = (mq.size() == DEPTH);
    grant = lv && !full;
    drn   = !grant && (mq.size() > 0);
    e_ld = 16'h0; e_addr = 16'h0; e_wd = 16'h0;
    if (grant) begin
      e_addr = la;
      e_ld   = exp_mem[la[2:0]];
      foreach (mq[k]) if (mq[k].a[2:0] == la[2:0]) e_ld = mq[k].d;
    end else if (drn) begin
      e_addr = mq[0].a;
      e_wd   = mq[0].d;
    end
    chk("rnd st_ready", st_ready, !full);
    chk("rnd ld_ready", ld_ready, !full);
    chk("rnd ld_data", ld_data, e_ld);
    chk("rnd mem_read", mem_read, grant);
    chk("rnd mem_write_en", mem_write_en, drn);
    chk("rnd mem_access_addr", mem_access_addr, e_addr);
    if (drn) chk("rnd mem_write_data", mem_write_data, e_wd);
    chk("rnd sb_count", sb_count, mq.size());
    chk("rnd sb_empty", sb_empty, mq.size() == 0);
    if (drn) begin
      exp_mem[mq[0].a[2:0]] = mq[0].d;
      void'(mq.pop_front());
    end
    if (sv && !full) mq.push_back('{a: sa, d: sd});
  endtask

  vec_t        tbl[18];
  logic [15:0] saved;
  int          n;

  initial begin
    rst_n = 0; mem_init = 1;
    st_valid = 0; st_addr = 0; st_data = 0; ld_valid = 0; ld_addr = 0;
    #1;
    chk("reset st_ready", st_ready, 1);
    chk("reset ld_ready", ld_ready, 1);
    chk("reset mem_write_en", mem_write_en, 0);
    chk("reset mem_read", mem_read, 0);
    chk("reset sb_empty", sb_empty, 1);
    chk("reset sb_count", sb_count, 0);
    chk("reset ld_data", ld_data, 0);
    chk("reset mem_access_addr", mem_access_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1; mem_init = 0;

    //           sv sa       sd        lv la        esr elr eld       we rd addr     wdata     cnt
    tbl[0]  = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
    tbl[1]  = mk(1, 16'h0003, 16'hBEEF, 0, 16'h0000, 1, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
    tbl[2]  = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000, 1, 0, 16'h0003, 16'hBEEF, 1);
    tbl[3]  = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
    tbl[4]  = mk(1, 16'h0005, 16'h1111, 1, 16'h0005, 1, 1, 16'hA005, 0, 1, 16'h0005, 16'h0000, 0);
    tbl[5]  = mk(1, 16'h0005, 16'h2222, 1, 16'h0005, 1, 1, 16'h1111, 0, 1, 16'h0005, 16'h0000, 1);
    tbl[6]  = mk(0, 16'h0000, 16'h0000, 1, 16'h0005, 1, 1, 16'h2222, 0, 1, 16'h0005, 16'h0000, 2);
    tbl[7]  = mk(1, 16'h000A, 16'h00AA, 1, 16'h0002, 1, 1, 16'hA002, 0, 1, 16'h0002, 16'h0000, 2);
    tbl[8]  = mk(0, 16'h0000, 16'h0000, 1, 16'h0002, 1, 1, 16'h00AA, 0, 1, 16'h0002, 16'h0000, 3);
    tbl[9]  = mk(1, 16'h0007, 16'h7777, 1, 16'h0007, 1, 1, 16'hA007, 0, 1, 16'h0007, 16'h0000, 3);
    tbl[10] = mk(1, 16'h0001, 16'h0101, 1, 16'h0005, 0, 0, 16'h0000, 1, 0, 16'h0005, 16'h1111, 4);
    tbl[11] = mk(1, 16'h0001, 16'h0101, 1, 16'h0005, 1, 1, 16'h2222, 0, 1, 16'h0005, 16'h0000, 3);
    tbl[12] = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0005, 16'h2222, 4);
    tbl[13] = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000, 1, 0, 16'h000A, 16'h00AA, 3);
    tbl[14] = mk(0, 16'h0000, 16'h0000, 1, 16'h0002, 1, 1, 16'h00AA, 0, 1, 16'h0002, 16'h0000, 2);
    tbl[15] = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000, 1, 0, 16'h0007, 16'h7777, 2);
    tbl[16] = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000, 1, 0, 16'h0001, 16'h0101, 1);
    tbl[17] = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].lv, tbl[i].la);
      chk($sformatf("row%0d st_ready", i), st_ready, tbl[i].e_st_rdy);
      chk($sformatf("row%0d ld_ready", i), ld_ready, tbl[i].e_ld_rdy);
      chk($sformatf("row%0d ld_data", i), ld_data, tbl[i].e_ld_data);
      chk($sformatf("row%0d mem_write_en", i), mem_write_en, tbl[i].e_we);
      chk($sformatf("row%0d mem_read", i), mem_read, tbl[i].e_rd);
      chk($sformatf("row%0d mem_access_addr", i), mem_access_addr, tbl[i].e_addr);
      if (tbl[i].e_we) chk($sformatf("row%0d mem_write_data", i), mem_write_data, tbl[i].e_wdata);
      chk($sformatf("row%0d sb_count", i), sb_count, tbl[i].e_cnt);
      chk($sformatf("row%0d sb_empty", i), sb_empty, tbl[i].e_cnt == 0);
    end

    // Pointer wrap: ten store/drain pairs leave head=tail=2, then three stores span indices 2,3,0.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 16'h0008 + 16'(i), 16'h5000 + 16'(i), 0, 16'h0000);
      drive(0, 16'h0000, 16'h0000, 0, 16'h0000);
      chk("wrap drain we", mem_write_en, 1);
      chk("wrap drain addr", mem_access_addr, 16'h0008 + 16'(i));
    end
    drive(1, 16'h0001, 16'h0001, 1, 16'h0006);
    drive(1, 16'h0001, 16'h0002, 1, 16'h0006);
    drive(1, 16'h0001, 16'h0003, 1, 16'h0006);
    drive(0, 16'h0000, 16'h0000, 1, 16'h0001);
    chk("wrap count", sb_count, 3);
    chk("wrap fwd ld_data", ld_data, 16'h0003);
    drive(0, 16'h0000, 16'h0000, 1, 16'h0009);
    chk("wrap alias ld_data", ld_data, 16'h0003);
    n = 0;
    while (!sb_empty && n < 10) begin
      drive(0, 16'h0000, 16'h0000, 0, 16'h0000);
      n++;
    end
    chk("wrap drained", sb_empty, 1);
    chk("wrap mem[1]", env_mem[1], 16'h0003);

    // Reset with stores pending: nothing may reach memory.
    saved = env_mem[4];
    drive(1, 16'h0004, 16'h4444, 1, 16'h0006);
    drive(1, 16'h0004, 16'h4445, 1, 16'h0006);
    drive(0, 16'h0000, 16'h0000, 0, 16'h0000);
    rst_n = 0;
    #1;
    chk("midrst sb_count", sb_count, 0);
    chk("midrst mem_write_en", mem_write_en, 0);
    chk("midrst sb_empty", sb_empty, 1);
    chk("midrst mem_access_addr", mem_access_addr, 0);
    chk("midrst ld_data", ld_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("midrst release st_ready", st_ready, 1);
    chk("midrst mem[4] untouched", env_mem[4], saved);

    // Random traffic against the model.
    do_reset();
    mq.delete();
    for (int i = 0; i < 8; i++) exp_mem[i] = 16'hA000 + 16'(i);
    for (int c = 0; c < 500; c++) begin
      step($urandom_range(0, 9) < 6, 16'($urandom_range(0, 31)), 16'($urandom),
           $urandom_range(0, 9) < 4, 16'($urandom_range(0, 31)));
    end
    for (int c = 0; c < DEPTH + 2; c++) step(0, 16'h0000, 16'h0000, 0, 16'h0000);
    chk("rnd final empty", sb_empty, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("rnd final mem[%0d]", i), env_mem[i], exp_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-store buffer between the core's MEM stage and Data_Memory.
- Accepts stores in one cycle, queues them in program order, and drains them into Data_Memory whenever the shared address port is not needed by a load.
- Loads are serviced combinationally: the youngest matching buffered store is forwarded; otherwise the load reads Data_Memory.
- The block owns Data_Memory's address/write/read ports.

Parameters:
- DEPTH, 4: number of store entries; power of two, ≥2.
- DATA_W, 16: data width.
- ADDR_W, 16: address width.
- MEM_AW, 3: low address bits decoded by Data_Memory. Forwarding match uses only these bits, so it follows memory aliasing.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  store request
- st_addr  in  ADDR_W  store address
- st_data  in  DATA_W  store data
- st_ready  out  1  store accepted this cycle (buffer not full)
- ld_valid  in  1  load request
- ld_addr  in  ADDR_W  load address
- ld_ready  out  1  load serviced this cycle
- ld_data  out  DATA_W  load result, valid when ld_valid&ld_ready
- mem_access_addr  out  ADDR_W  to Data_Memory
- mem_write_data  out  DATA_W  to Data_Memory
- mem_write_en  out  1  to Data_Memory
- mem_read  out  1  to Data_Memory
- mem_read_data  in  DATA_W  from Data_Memory
- sb_empty  out  1  no pending stores (fence/halt condition)
- sb_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, rst_n=0):
  - All entries invalid; head, tail and count are 0.
  - Outputs: st_ready=1, ld_ready=1, mem_write_en=0, mem_read=0, sb_empty=1, sb_count=0, ld_data=0, mem_access_addr=0.
  - Reset mid-drain discards all pending stores; no partial write occurs because mem_write_en drops immediately.
- State: circular FIFO of {addr, data}, with head (oldest), tail and count registers. All outputs are combinational from state and inputs; no extra latency.
- Full/empty:
  - full = (count==DEPTH); st_ready = !full.
  - Enqueue on st_valid&st_ready at the clock edge: write the tail entry, tail+1 mod DEPTH.
  - No same-cycle bypass when full: a drain while full does not raise st_ready that cycle.
- Port arbitration, evaluated each cycle:
  1. full & ld_valid: drain wins. ld_ready=0 and the load stalls (anti-starvation).
  2. ld_valid & !full: load wins. ld_ready=1, mem_read=1, mem_access_addr=ld_addr, mem_write_en=0.
  3. Otherwise, if count>0: drain. mem_write_en=1, mem_access_addr=head.addr, mem_write_data=head.data. Head+1 and the entry frees at this edge, coincident with the memory write.
  4. Idle: mem_write_en=0, mem_read=0, mem_access_addr=0.
- Forwarding:
  - Compare ld_addr[MEM_AW-1:0] against every valid entry.
  - On any match, ld_data is the youngest matching entry (closest to tail) and memory data is ignored.
  - No match: ld_data = mem_read_data.
  - ld_data=0 when the load is not granted.
- Simultaneous events:
  - Enqueue and drain in the same cycle: count unchanged.
  - A store accepted in the same cycle as a load is NOT visible to that load.
  - Wrap-around: pointers wrap mod DEPTH; forwarding age order is computed relative to head, never by raw index.
- sb_empty = (count==0).

Decomposition:
- DEPTH/MEM_AW defaults added as `define entries in src/Parameter.v next to row_d/col.
- One sub-module, sb_fwd_match: takes the entry arrays, valid vector, head and ld_addr; returns hit and forwarded data (youngest-first priority). It is purely combinational and tested standalone.

Test Plan:
- Reset then idle: rst_n=0 mid-run → outputs at reset values immediately, sb_count=0, mem_write_en=0; release → st_ready=1.
- Store A=0x0003 D=0xBEEF with no loads → next cycle mem_write_en=1, addr=0x0003, data=0xBEEF; following cycle sb_empty=1.
- Two stores to 0x0005 (0x1111 then 0x2222) with a load from 0x0005 held every cycle → ld_data=0x2222, mem_read=1, no drain while !full.
- Alias check: store 0x000A=0x00AA buffered, load 0x0002 → forwarded 0x00AA (low 3 bits match).
- Fill to DEPTH with a continuous load stream → st_ready=0, ld_ready=0, head drains one cycle; then ld_ready=1 and count=DEPTH-1.
- Wrap: 10 store/drain interleavings, then 3 stores to 0x0001 = 1, 2, 3 straddling the pointer wrap → load 0x0001 returns 3; final memory[1]=3 after drain.
